instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 32 +++
 rtl/instruction_fetch.sv | 105 ++++++++++
 tb/tb_instruction_fetch.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction-fetch bus bundle (memory side + decode side)
// Purpose: groups the instruction-memory request bus and the decode handshake.
// Ports (signals):
//   imem_addr[7:0], imem_req         fetch unit -> instruction memory
//   imem_ack, imem_rdata[7:0]        instruction memory -> fetch unit
//   instruction[7:0], instr_pc[7:0],
//   instr_valid                      fetch unit -> decode/control
//   instr_ready, jump[7:0],
//   jump_target[7:0]                 decode/control -> fetch unit
// Modports: master = fetch unit, slave = memory/decode environment.
interface instruction_fetch_if;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] instruction;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] jump;
    logic [7:0] jump_target;
    logic [7:0] instr_pc;

    modport master (
        output imem_addr, imem_req, instruction, instr_valid, instr_pc,
        input  imem_ack, imem_rdata, instr_ready, jump, jump_target
    );

    modport slave (
        input  imem_addr, imem_req, instruction, instr_valid, instr_pc,
        output imem_ack, imem_rdata, instr_ready, jump, jump_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - three-state instruction fetch unit with redirect
// Purpose: fetches one instruction byte per PC from instruction memory, holds it
// for the decode stage until accepted, then advances the PC (or redirects).
// Ports:
//   clk                 sole clock, rising edge
//   rst                 synchronous, active-high reset
//   bus                 instruction_fetch_if.master (memory bus + decode handshake)
//   fetch_count[15:0]   accepted instructions, saturating   (IF_PERF_EN only)
//   stall_count[15:0]   stalled REQ/HOLD cycles, saturating (IF_PERF_EN only)
// Build option: define IF_PERF_EN to compile in the performance counters.
module instruction_fetch (
    input  logic                       clk,
    input  logic                       rst,
`ifdef IF_PERF_EN
    output logic [15:0]                fetch_count,
    output logic [15:0]                stall_count,
`endif
    instruction_fetch_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] instr_q;
    logic [7:0] instr_pc_q;
    logic       instr_valid_q;
    logic       imem_req_q;

    // Accept can only happen in HOLD, where instr_valid is always set.
    logic accept;
    assign accept = (state == HOLD) && bus.instr_ready;

    assign bus.imem_addr   = pc;
    assign bus.imem_req    = imem_req_q;
    assign bus.instruction = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= 8'h00;
            instr_q       <= 8'h00;
            instr_pc_q    <= 8'h00;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    // Without ack the PC and request simply hold; no timeout.
                    if (bus.imem_ack) begin
                        instr_q       <= bus.imem_rdata;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    // jump/jump_target are only looked at on the accept edge.
                    if (accept) begin
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                        pc            <= (bus.jump != 8'h00) ? bus.jump_target : pc + 8'd1;
                        state         <= REQ;
                    end
                end
                default: begin
                    state         <= IDLE;
                    instr_valid_q <= 1'b0;
                    imem_req_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_EN
    logic stall;
    assign stall = ((state == REQ) && !bus.imem_ack) || ((state == HOLD) && !bus.instr_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'h0000;
            stall_count <= 16'h0000;
        end else begin
            if (accept && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

`ifdef IF_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IF_PERF_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .bus         (bus)
    );

    typedef struct {
        logic [7:0] rdata;
        int         ack_wait;
        int         ready_wait;
        logic [7:0] jump;
        logic [7:0] tgt;
        logic [7:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] pc;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_accept  = 0;

`ifdef IF_PERF_EN
    int exp_fetch = 0;
    int exp_stall = 0;
`endif

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input vec_t v, input bit chk_rate);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            step();
            n++;
        end
        check("req_seen", {31'd0, bus.imem_req}, 32'd1);
        check("imem_addr", {24'd0, bus.imem_addr}, {24'd0, v.exp_addr});
        sb.push_back('{instr: v.rdata, pc: v.exp_addr});

        for (int k = 0; k < v.ack_wait; k++) begin
            bus.imem_ack    = 1'b0;
            bus.imem_rdata  = 8'($urandom);
            bus.jump        = 8'hFF;
            bus.jump_target = 8'h99;
            step();
            check("stall_req", {31'd0, bus.imem_req}, 32'd1);
            check("stall_addr", {24'd0, bus.imem_addr}, {24'd0, v.exp_addr});
            check("stall_valid", {31'd0, bus.instr_valid}, 32'd0);
        end

        bus.imem_ack   = 1'b1;
        bus.imem_rdata = v.rdata;
        bus.jump       = 8'h00;
        step();
        bus.imem_ack = 1'b0;
        check("valid_set", {31'd0, bus.instr_valid}, 32'd1);
        check("req_clr", {31'd0, bus.imem_req}, 32'd0);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            e = '{instr: 8'h00, pc: 8'h00};
        end else begin
            e = sb.pop_front();
        end
        check("instruction", {24'd0, bus.instruction}, {24'd0, e.instr});
        check("instr_pc", {24'd0, bus.instr_pc}, {24'd0, e.pc});

        for (int k = 0; k < v.ready_wait; k++) begin
            bus.instr_ready = 1'b0;
            bus.imem_ack    = 1'($urandom);
            bus.imem_rdata  = 8'($urandom);
            bus.jump        = 8'hFF;
            bus.jump_target = 8'h99;
            step();
            check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
            check("hold_instr", {24'd0, bus.instruction}, {24'd0, e.instr});
            check("hold_pc", {24'd0, bus.instr_pc}, {24'd0, e.pc});
        end

        bus.instr_ready = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.jump        = v.jump;
        bus.jump_target = v.tgt;
        step();
        bus.instr_ready = 1'b0;
        bus.jump        = 8'h00;
        bus.jump_target = 8'h00;
        check("valid_clr", {31'd0, bus.instr_valid}, 32'd0);
        if (chk_rate) begin
            check("throughput", cyc - last_accept, 32'd2);
        end
        last_accept = cyc;
`ifdef IF_PERF_EN
        exp_fetch += 1;
        exp_stall += v.ack_wait + v.ready_wait;
`endif
    endtask

    initial begin
        vecs[0] = '{rdata: 8'h10, ack_wait: 0, ready_wait: 0, jump: 8'h00, tgt: 8'h00, exp_addr: 8'h00};
        vecs[1] = '{rdata: 8'h21, ack_wait: 0, ready_wait: 0, jump: 8'h00, tgt: 8'h00, exp_addr: 8'h01};
        vecs[2] = '{rdata: 8'h32, ack_wait: 5, ready_wait: 0, jump: 8'h00, tgt: 8'h00, exp_addr: 8'h02};
        vecs[3] = '{rdata: 8'h43, ack_wait: 0, ready_wait: 3, jump: 8'h00, tgt: 8'h00, exp_addr: 8'h03};
        vecs[4] = '{rdata: 8'h54, ack_wait: 0, ready_wait: 0, jump: 8'h00, tgt: 8'h00, exp_addr: 8'h04};
        vecs[5] = '{rdata: 8'h65, ack_wait: 1, ready_wait: 2, jump: 8'hFF, tgt: 8'h40, exp_addr: 8'h05};
        vecs[6] = '{rdata: 8'h76, ack_wait: 0, ready_wait: 0, jump: 8'h01, tgt: 8'hFE, exp_addr: 8'h40};
        vecs[7] = '{rdata: 8'h87, ack_wait: 0, ready_wait: 0, jump: 8'h00, tgt: 8'h12, exp_addr: 8'hFE};
        vecs[8] = '{rdata: 8'h98, ack_wait: 2, ready_wait: 0, jump: 8'h00, tgt: 8'h00, exp_addr: 8'hFF};
        vecs[9] = '{rdata: 8'hA9, ack_wait: 0, ready_wait: 1, jump: 8'h00, tgt: 8'h00, exp_addr: 8'h00};

        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 8'h00;
        bus.instr_ready = 1'b0;
        bus.jump        = 8'h00;
        bus.jump_target = 8'h00;

        // Reset with every input asserted: reset must win.
        rst             = 1'b1;
        bus.imem_ack    = 1'b1;
        bus.instr_ready = 1'b1;
        bus.jump        = 8'hFF;
        bus.jump_target = 8'h55;
        repeat (3) step();
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("rst_instr", {24'd0, bus.instruction}, 32'd0);
        check("rst_ipc", {24'd0, bus.instr_pc}, 32'd0);
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jump        = 8'h00;
        bus.jump_target = 8'h00;

        // IDLE lasts exactly one cycle after reset is released.
        rst = 1'b0;
        step();
        check("idle_to_req", {31'd0, bus.imem_req}, 32'd1);
        last_accept = cyc;

        for (int i = 0; i < 10; i++) begin
            do_fetch(vecs[i], (i > 0) && vecs[i].ack_wait == 0 && vecs[i].ready_wait == 0 &&
                              vecs[i-1].ack_wait == 0 && vecs[i-1].ready_wait == 0);
        end
        check("sb_drained", sb.size(), 32'd0);

`ifdef IF_PERF_EN
        check("fetch_count", {16'd0, fetch_count}, 32'(exp_fetch));
        check("stall_count", {16'd0, stall_count}, 32'(exp_stall));
`endif

        // Reset in REQ coincident with ack: the fetch is discarded.
        check("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
        rst            = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'hEE;
        step();
        rst          = 1'b0;
        bus.imem_ack = 1'b0;
        check("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("mid_rst_instr", {24'd0, bus.instruction}, 32'd0);
        check("mid_rst_ipc", {24'd0, bus.instr_pc}, 32'd0);
        check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
`ifdef IF_PERF_EN
        check("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
        check("rst_stall_count", {16'd0, stall_count}, 32'd0);
`endif
        step();
        check("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        check("post_rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'h77;
        step();
        bus.imem_ack = 1'b0;
        check("post_rst_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("post_rst_instr", {24'd0, bus.instruction}, 32'h77);
        check("post_rst_ipc", {24'd0, bus.instr_pc}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
